// File: rtl/rx_iq_frame_streamer.sv
// Captures multi-channel I/Q frames into a word FIFO, then streams each {I,Q} word out
// DW bits at a time, MSB first, advancing on a consumer strobe.
`timescale 1ns/1ps
module rx_iq_frame_streamer #(
    parameter int unsigned NR    = 6,
    parameter int unsigned SW    = 24,
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [NR*SW-1:0]   in_i,
    input  logic [NR*SW-1:0]   in_q,
    input  logic [3:0]         nr_active,
    input  logic               rd_strobe,
    output logic [DW-1:0]      out_data,
    output logic               out_samples,
    output logic [7:0]         overflow_cnt
);

    localparam int unsigned WW  = 2 * SW;
    localparam int unsigned NPW = WW / DW;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned SCW = $clog2(NPW + 1);

    typedef enum logic {StIdle, StWrite} state_t;

    state_t              r_state;
    logic [NR*SW-1:0]    r_lat_i;
    logic [NR*SW-1:0]    r_lat_q;
    logic [3:0]          r_n;
    logic [3:0]          r_k;
    logic [7:0]          r_ovf;

    logic [WW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [WW-1:0]       r_sh;
    logic [SCW-1:0]      r_sh_cnt;

    logic [3:0]          w_n;
    logic [CW-1:0]       w_free;
    logic                w_wr_en;
    logic [WW-1:0]       w_wr_word;
    logic                w_sh_empty;
    logic                w_sh_last;
    logic                w_rd_en;
    logic                w_drop;
    logic                w_accept;
    logic [CW:0]         w_pending;
    logic [3:0]          w_inflight;

    always_comb begin
        if (nr_active == 4'd0) begin
            w_n = 4'd1;
        end else if (32'(nr_active) > NR) begin
            w_n = 4'(NR);
        end else begin
            w_n = nr_active;
        end
    end

    always_comb begin
        w_wr_word = '0;
        for (int c = 0; c < NR; c++) begin
            if (32'(r_k) == c) begin
                w_wr_word = {r_lat_i[c*SW +: SW], r_lat_q[c*SW +: SW]};
            end
        end
    end

    assign w_free     = CW'(DEPTH) - r_count;
    assign w_wr_en    = (r_state == StWrite);
    assign w_sh_empty = (r_sh_cnt == '0);
    assign w_sh_last  = rd_strobe && (r_sh_cnt == SCW'(1));
    // Final strobe of a word pulls the next one in the same edge, so the stream has no bubble.
    assign w_rd_en    = (r_count != '0) && (w_sh_empty || w_sh_last);
    assign w_drop     = in_valid && ((r_state == StWrite) || (32'(w_free) < 32'(w_n)));
    assign w_accept   = in_valid && !w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_lat_i <= '0;
            r_lat_q <= '0;
            r_n     <= 4'd1;
            r_k     <= 4'd0;
            r_ovf   <= 8'd0;
        end else begin
            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_lat_i <= in_i;
                        r_lat_q <= in_q;
                        r_n     <= w_n;
                        r_k     <= 4'd0;
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    if (r_k == r_n - 4'd1) begin
                        r_k     <= 4'd0;
                        r_state <= StIdle;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    // Zeros shift in from the bottom, so an exhausted register reads back as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh     <= '0;
            r_sh_cnt <= '0;
        end else if (w_rd_en) begin
            r_sh     <= r_mem[r_rd_ptr];
            r_sh_cnt <= SCW'(NPW);
        end else if (rd_strobe && !w_sh_empty) begin
            r_sh     <= r_sh << DW;
            r_sh_cnt <= r_sh_cnt - SCW'(1);
        end
    end

    // Words of the frame still being written are the youngest pending words; anything beyond
    // them belongs to a completed frame.
    assign w_pending  = (CW + 1)'(r_count) + (CW + 1)'(!w_sh_empty);
    assign w_inflight = (r_state == StWrite) ? r_k : 4'd0;

    assign out_data     = r_sh[WW-1 -: DW];
    assign out_samples  = (32'(w_pending) > 32'(w_inflight));
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_rx_iq_frame_streamer.sv
// Directed self-checking bench for rx_iq_frame_streamer (NR=6, SW=24, DW=4, DEPTH=16).
`timescale 1ns/1ps
module tb_rx_iq_frame_streamer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [143:0] in_i = '0;
    logic [143:0] in_q = '0;
    logic [3:0]   nr_active = 4'd2;
    logic         rd_strobe = 1'b0;
    logic [3:0]   out_data;
    logic         out_samples;
    logic [7:0]   overflow_cnt;

    int checks = 0;
    int failures = 0;

    rx_iq_frame_streamer #(
        .NR(6), .SW(24), .DW(4), .DEPTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_i         (in_i),
        .in_q         (in_q),
        .nr_active    (nr_active),
        .rd_strobe    (rd_strobe),
        .out_data     (out_data),
        .out_samples  (out_samples),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk_i(input int f, input int c);
        return {4'(f + 1), 4'(c + 1), 16'hA5C3};
    endfunction

    function automatic logic [23:0] mk_q(input int f, input int c);
        return {4'hB, 4'(c + 1), 4'(f + 1), 12'h96E};
    endfunction

    function automatic logic [3:0] nib(input logic [47:0] w, input int j);
        logic [47:0] t;
        t = w >> (44 - 4 * j);
        return t[3:0];
    endfunction

    task automatic load_frame(input int f);
        for (int c = 0; c < 6; c++) begin
            in_i[c*24 +: 24] = mk_i(f, c);
            in_q[c*24 +: 24] = mk_q(f, c);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits (bounded) for a pending frame, then strobes until nothing is pending.
    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 20 && !out_samples; i++) tick();
        tick();
        while (out_samples && n < 200) begin
            rd_strobe = 1'b1;
            tick();
            n++;
        end
        rd_strobe = 1'b0;
    endtask

    logic [47:0] w2 [2];
    logic [47:0] exp_w [20];
    int n;

    initial begin
        // Reset values, asserted asynchronously before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_samples", out_samples, 0);
        chk("rst_overflow", overflow_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Two-channel frame, nibble order MSB first, I before Q
        nr_active = 4'd2;
        in_i[23:0]  = 24'hABCDEF;
        in_q[23:0]  = 24'h123456;
        in_i[47:24] = 24'h789ABC;
        in_q[47:24] = 24'hDEF012;
        w2[0] = 48'hABCDEF123456;
        w2[1] = 48'h789ABCDEF012;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t1_partial_frame_samples", out_samples, 0);
        chk("t1_partial_frame_data", out_data, 0);
        tick();
        chk("t1_samples_rise", out_samples, 1);
        for (int wi = 0; wi < 2; wi++) begin
            for (int j = 0; j < 12; j++) begin
                chk("t1_nibble", out_data, nib(w2[wi], j));
                rd_strobe = 1'b1;
                tick();
            end
        end
        rd_strobe = 1'b0;
        chk("t1_samples_fall", out_samples, 0);
        chk("t1_data_idle", out_data, 0);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        chk("t1_strobe_when_empty", out_data, 0);
        chk("t1_no_overflow", overflow_cnt, 0);

        // nr_active clamping, sampled only at acceptance
        nr_active = 4'd0;
        load_frame(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(n);
        chk("t2_clamp_low_nibbles", n, 12);
        nr_active = 4'd9;
        load_frame(2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nr_active = 4'd1;
        drain(n);
        chk("t2_clamp_high_nibbles", n, 72);

        // Back-to-back strobes: second frame dropped
        nr_active = 4'd3;
        load_frame(3);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t3_overflow", overflow_cnt, 1);
        drain(n);
        chk("t3_nibbles", n, 36);

        // FIFO full: frames 3-4 dropped, then saturation
        pulse_reset();
        chk("t4_overflow_after_reset", overflow_cnt, 0);
        nr_active = 4'd6;
        for (int fr = 0; fr < 4; fr++) begin
            load_frame(fr);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
            if (fr == 1) chk("t4_two_accepted", overflow_cnt, 0);
        end
        chk("t4_two_dropped", overflow_cnt, 2);
        chk("t4_samples_pending", out_samples, 1);
        chk("t4_head_nibble", out_data, 4'h1);
        in_valid = 1'b1;
        repeat (300) tick();
        chk("t4_saturated", overflow_cnt, 255);
        tick();
        in_valid = 1'b0;
        chk("t4_stays_saturated", overflow_cnt, 255);

        // Reset in the middle of a 6-channel WRITE
        pulse_reset();
        nr_active = 4'd6;
        load_frame(4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_streaming_before_reset", out_data, 4'h5);
        rst = 1'b1;
        #1;
        chk("t5_async_out_data", out_data, 0);
        chk("t5_async_samples", out_samples, 0);
        chk("t5_async_overflow", overflow_cnt, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_strobe = 1'b1;
            tick();
            chk("t5_no_residual_data", out_data, 0);
            chk("t5_no_residual_samples", out_samples, 0);
        end
        rd_strobe = 1'b0;
        nr_active = 4'd2;
        load_frame(5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(n);
        chk("t5_first_frame_complete", n, 24);

        // Continuous streaming with writes in flight; 20 words wrap the 16-deep FIFO
        nr_active = 4'd4;
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 4; c++) begin
                exp_w[f*4 + c] = {mk_i(f + 6, c), mk_q(f + 6, c)};
            end
        end
        for (int f = 6; f < 9; f++) begin
            load_frame(f);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (7) tick();
        end
        for (int cyc = 0; cyc < 240; cyc++) begin
            if (cyc == 30) begin
                load_frame(9);
                in_valid = 1'b1;
            end else if (cyc == 90) begin
                load_frame(10);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            rd_strobe = 1'b1;
            chk("t6_stream_nibble", out_data, nib(exp_w[cyc / 12], cyc % 12));
            tick();
        end
        rd_strobe = 1'b0;
        in_valid = 1'b0;
        chk("t6_samples_done", out_samples, 0);
        chk("t6_no_overflow", overflow_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
